// File: rtl/game_result_tracker_if.sv
// Handshake and status bundle between the game counter, the result consumer and the tracker.
// With GRT_OVERFLOW_FLAG_EN defined the bundle also carries the sticky overflow flag.
interface game_result_tracker_if;
    logic       GAMEOVER;
    logic [1:0] WHO;
    logic       new_series;
    logic       res_ready;
    logic       res_valid;
    logic [1:0] res_data;
    logic [3:0] wins;
    logic [3:0] losses;
    logic       clear_req;
    logic       series_done;
    logic [1:0] series_winner;
`ifdef GRT_OVERFLOW_FLAG_EN
    logic       overflow;
`endif

    modport slave (
        input  GAMEOVER, WHO, new_series, res_ready,
        output res_valid, res_data, wins, losses, clear_req, series_done, series_winner
`ifdef GRT_OVERFLOW_FLAG_EN
        , output overflow
`endif
    );

    modport master (
        output GAMEOVER, WHO, new_series, res_ready,
        input  res_valid, res_data, wins, losses, clear_req, series_done, series_winner
`ifdef GRT_OVERFLOW_FLAG_EN
        , input overflow
`endif
    );
endinterface

// File: rtl/game_result_tracker.sv
// Best-of-N series tracker: tallies game results, pulses the counter clear and queues results.
// Optional GRT_OVERFLOW_FLAG_EN adds a sticky flag for results dropped on a full FIFO.
module game_result_tracker #(
    parameter int SERIES_LEN = 5,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    game_result_tracker_if.slave bus
);
    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] MAJ      = 4'(SERIES_LEN / 2 + 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {PLAY, DONE} state_t;

    state_t        r_state;
    logic          r_gameOverPrev;
    logic          r_armed;
    logic [3:0]    r_wins;
    logic [3:0]    r_losses;
    logic [1:0]    r_winner;
    logic          r_clearReq;
    logic [1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;

    logic w_event;
    logic w_validWho;
    logic w_accept;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // r_armed masks the first cycle after reset so a level already high is not taken as an edge.
    assign w_event    = r_armed & bus.GAMEOVER & ~r_gameOverPrev;
    assign w_validWho = (bus.WHO == 2'b10) || (bus.WHO == 2'b01);
    assign w_accept   = w_event && (r_state == PLAY) && w_validWho && !bus.new_series;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = !w_empty && bus.res_ready;
    assign w_push     = w_accept && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= PLAY;
            r_gameOverPrev <= 1'b0;
            r_armed        <= 1'b0;
            r_wins         <= 4'd0;
            r_losses       <= 4'd0;
            r_winner       <= 2'b00;
            r_clearReq     <= 1'b0;
        end else begin
            r_gameOverPrev <= bus.GAMEOVER;
            r_armed        <= 1'b1;
            r_clearReq     <= w_accept;
            if (bus.new_series) begin
                r_state  <= PLAY;
                r_wins   <= 4'd0;
                r_losses <= 4'd0;
                r_winner <= 2'b00;
            end else if (w_accept) begin
                if (bus.WHO == 2'b10) begin
                    if (r_wins < MAJ) r_wins <= r_wins + 4'd1;
                    if (r_wins + 4'd1 == MAJ) begin
                        r_state  <= DONE;
                        r_winner <= 2'b10;
                    end
                end else begin
                    if (r_losses < MAJ) r_losses <= r_losses + 4'd1;
                    if (r_losses + 4'd1 == MAJ) begin
                        r_state  <= DONE;
                        r_winner <= 2'b01;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= bus.WHO;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef GRT_OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_accept && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow = r_overflow;
`endif

    assign bus.res_valid     = !w_empty;
    assign bus.res_data      = w_empty ? 2'b00 : r_mem[r_rdPtr];
    assign bus.wins          = r_wins;
    assign bus.losses        = r_losses;
    assign bus.clear_req     = r_clearReq;
    assign bus.series_done   = (r_state == DONE);
    assign bus.series_winner = r_winner;
endmodule

// File: tb/tb_game_result_tracker.sv
// Directed bench for game_result_tracker: a default instance plus a SERIES_LEN=15 instance for overflow.
// Overflow flag checks are included when GRT_OVERFLOW_FLAG_EN is defined.
module tb_game_result_tracker;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   pulses;
    logic [1:0] expB [4];

    always #5 clk = ~clk;

    game_result_tracker_if ifA ();
    game_result_tracker_if ifB ();

    game_result_tracker dutA (
        .clk(clk),
        .rst(rst),
        .bus(ifA)
    );

    game_result_tracker #(.SERIES_LEN(15), .FIFO_DEPTH(4)) dutB (
        .clk(clk),
        .rst(rst),
        .bus(ifB)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rising GAMEOVER on instance A for one cycle, leaving outputs as seen just after the edge.
    task automatic applyStimulus(input logic [1:0] who);
        ifA.GAMEOVER = 1'b1;
        ifA.WHO      = who;
        tick();
        ifA.GAMEOVER = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifA.GAMEOVER = 1'b0; ifA.WHO = 2'b00; ifA.new_series = 1'b0; ifA.res_ready = 1'b0;
        ifB.GAMEOVER = 1'b0; ifB.WHO = 2'b00; ifB.new_series = 1'b0; ifB.res_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_wins", 8'(ifA.wins), 8'd0);
        checkOutput("rst_losses", 8'(ifA.losses), 8'd0);
        checkOutput("rst_clear", 8'(ifA.clear_req), 8'd0);
        checkOutput("rst_valid", 8'(ifA.res_valid), 8'd0);
        checkOutput("rst_data", 8'(ifA.res_data), 8'd0);
        checkOutput("rst_done", 8'(ifA.series_done), 8'd0);
        checkOutput("rst_winner", 8'(ifA.series_winner), 8'd0);
`ifdef GRT_OVERFLOW_FLAG_EN
        checkOutput("rst_overflow", 8'(ifB.overflow), 8'd0);
`endif
        rst = 1'b0;
        tick();

        // Three wins end a best-of-5; each result is popped the cycle after it lands.
        ifA.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b10);
            checkOutput("win_tally", 8'(ifA.wins), 8'(i + 1));
            checkOutput("win_clear", 8'(ifA.clear_req), 8'd1);
            checkOutput("win_valid", 8'(ifA.res_valid), 8'd1);
            checkOutput("win_data", 8'(ifA.res_data), 8'h2);
            tick();
            checkOutput("win_clear_end", 8'(ifA.clear_req), 8'd0);
            checkOutput("win_popped", 8'(ifA.res_valid), 8'd0);
        end
        checkOutput("win_done", 8'(ifA.series_done), 8'd1);
        checkOutput("win_winner", 8'(ifA.series_winner), 8'h2);

        ifA.new_series = 1'b1;
        tick();
        ifA.new_series = 1'b0;
        checkOutput("ns_done", 8'(ifA.series_done), 8'd0);
        checkOutput("ns_wins", 8'(ifA.wins), 8'd0);
        checkOutput("ns_winner", 8'(ifA.series_winner), 8'd0);

        // A long GAMEOVER level is one event only.
        ifA.GAMEOVER = 1'b1;
        ifA.WHO      = 2'b01;
        tick();
        pulses = int'(ifA.clear_req);
        repeat (9) begin
            tick();
            pulses += int'(ifA.clear_req);
        end
        checkOutput("hold_pulses", 8'(pulses), 8'd1);
        checkOutput("hold_losses", 8'(ifA.losses), 8'd1);
        checkOutput("hold_wins", 8'(ifA.wins), 8'd0);
        ifA.GAMEOVER = 1'b0;
        tick();

        applyStimulus(2'b00);
        checkOutput("none_clear", 8'(ifA.clear_req), 8'd0);
        checkOutput("none_losses", 8'(ifA.losses), 8'd1);
        checkOutput("none_valid", 8'(ifA.res_valid), 8'd0);
        ifA.WHO = 2'b00;
        tick();

        // new_series wins over a simultaneous event.
        ifA.new_series = 1'b1;
        applyStimulus(2'b10);
        ifA.new_series = 1'b0;
        checkOutput("prio_wins", 8'(ifA.wins), 8'd0);
        checkOutput("prio_losses", 8'(ifA.losses), 8'd0);
        checkOutput("prio_clear", 8'(ifA.clear_req), 8'd0);
        checkOutput("prio_valid", 8'(ifA.res_valid), 8'd0);
        tick();

        // Fill the FIFO while reaching DONE, then verify DONE ignores events and new_series keeps the FIFO.
        ifA.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b10);
            tick();
        end
        checkOutput("fill_done", 8'(ifA.series_done), 8'd1);
        checkOutput("fill_winner", 8'(ifA.series_winner), 8'h2);
        applyStimulus(2'b01);
        checkOutput("done_losses", 8'(ifA.losses), 8'd0);
        checkOutput("done_clear", 8'(ifA.clear_req), 8'd0);
        checkOutput("done_wins", 8'(ifA.wins), 8'd3);
        tick();
        ifA.new_series = 1'b1;
        tick();
        ifA.new_series = 1'b0;
        checkOutput("keep_done", 8'(ifA.series_done), 8'd0);
        checkOutput("keep_wins", 8'(ifA.wins), 8'd0);
        checkOutput("keep_winner", 8'(ifA.series_winner), 8'd0);
        checkOutput("keep_valid", 8'(ifA.res_valid), 8'd1);
        ifA.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("keep_pop_valid", 8'(ifA.res_valid), 8'd1);
            checkOutput("keep_pop_data", 8'(ifA.res_data), 8'h2);
            tick();
        end
        checkOutput("keep_empty", 8'(ifA.res_valid), 8'd0);
        checkOutput("keep_empty_data", 8'(ifA.res_data), 8'd0);

        // Six alternating results into a 4-deep FIFO that is not drained.
        expB[0] = 2'b10; expB[1] = 2'b01; expB[2] = 2'b10; expB[3] = 2'b01;
        for (int i = 0; i < 6; i++) begin
            ifB.GAMEOVER = 1'b1;
            ifB.WHO      = (i % 2 == 0) ? 2'b10 : 2'b01;
            tick();
            ifB.GAMEOVER = 1'b0;
            tick();
        end
        checkOutput("ovf_wins", 8'(ifB.wins), 8'd3);
        checkOutput("ovf_losses", 8'(ifB.losses), 8'd3);
        checkOutput("ovf_done", 8'(ifB.series_done), 8'd0);
`ifdef GRT_OVERFLOW_FLAG_EN
        checkOutput("ovf_flag", 8'(ifB.overflow), 8'd1);
`endif
        ifB.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("ovf_pop_valid", 8'(ifB.res_valid), 8'd1);
            checkOutput("ovf_pop_data", 8'(ifB.res_data), 8'(expB[k]));
            tick();
        end
        checkOutput("ovf_empty", 8'(ifB.res_valid), 8'd0);
        ifB.res_ready = 1'b0;

        // Reset right after an accepted event, with GAMEOVER left high across reset.
        ifA.res_ready = 1'b0;
        applyStimulus(2'b01);
        checkOutput("pre_rst_clear", 8'(ifA.clear_req), 8'd1);
        checkOutput("pre_rst_losses", 8'(ifA.losses), 8'd1);
        ifA.GAMEOVER = 1'b1;
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_clear", 8'(ifA.clear_req), 8'd0);
        checkOutput("mid_rst_valid", 8'(ifA.res_valid), 8'd0);
        checkOutput("mid_rst_data", 8'(ifA.res_data), 8'd0);
        checkOutput("mid_rst_losses", 8'(ifA.losses), 8'd0);
        checkOutput("mid_rst_done", 8'(ifA.series_done), 8'd0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_clear", 8'(ifA.clear_req), 8'd0);
        tick();
        checkOutput("post_rst_clear2", 8'(ifA.clear_req), 8'd0);
        checkOutput("post_rst_losses", 8'(ifA.losses), 8'd0);
        checkOutput("post_rst_valid", 8'(ifA.res_valid), 8'd0);
`ifdef GRT_OVERFLOW_FLAG_EN
        checkOutput("post_rst_overflow", 8'(ifB.overflow), 8'd0);
`endif
        ifA.GAMEOVER = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
